c_and: RTL and testbench

//  - Parameterised bitwise 2-input AND gate for the "compuertas" gate library.
//  - Default configuration is a purely combinational 1-bit AND: y = a & b.
//  - Optional output pipeline stages add registered latency.
//  - A status counter records qualified cycles where y is all-ones.

---
 rtl/c_and_pkg.sv | 22 ++
 rtl/c_and_pipe_reg.sv | 35 +++
 rtl/c_and.sv | 81 ++++++++
 tb/tb_c_and.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/c_and_pkg.sv
// c_and_pkg
//   Shared constants and helpers for the c_and gate in the compuertas library.
//   MAX_PIPE_STAGES : deepest supported output pipeline.
//   DEFAULT_COUNT_W : default width of the hit counter.
//   MAX_WIDTH       : widest operand supported by all_ones().
//   all_ones(width) : mask with the low 'width' bits set.
package c_and_pkg;

  localparam int MAX_PIPE_STAGES = 8;
  localparam int DEFAULT_COUNT_W = 16;
  localparam int MAX_WIDTH       = 64;

  function automatic logic [MAX_WIDTH-1:0] all_ones(input int width);
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/c_and_pipe_reg.sv
// c_and_pipe_reg
//   One output pipeline stage of c_and: WIDTH data bits plus a valid bit,
//   both cleared by a synchronous active-high reset.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   i_d   : stage data in        o_d   : stage data out
//   i_vld : stage valid in       o_vld : stage valid out
module c_and_pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_vld,
  output logic [WIDTH-1:0] o_d,
  output logic             o_vld
);

  logic [WIDTH-1:0] r_d;
  logic             r_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d   <= '0;
      r_vld <= 1'b0;
    end else begin
      r_d   <= i_d;
      r_vld <= i_vld;
    end
  end

  assign o_d   = r_d;
  assign o_vld = r_vld;

endmodule

// File: rtl/c_and.sv
// c_and
//   Parameterised bitwise 2-input AND with optional output pipeline and a
//   saturating counter of qualified all-ones results.
//   Parameters: WIDTH (operand width, <= MAX_WIDTH), PIPE_STAGES (0..8,
//   0 = combinational), COUNT_W (hit counter width).
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   a, b      : operands
//   in_valid  : qualifies a/b for out_valid and hit_count (never gates y)
//   y         : a & b after PIPE_STAGES cycles
//   out_valid : in_valid after PIPE_STAGES cycles
//   hit_count : saturating count of qualified results equal to all-ones
module c_and
  import c_and_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int PIPE_STAGES = 0,
  parameter int COUNT_W     = DEFAULT_COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               in_valid,
  output logic [WIDTH-1:0]   y,
  output logic               out_valid,
  output logic [COUNT_W-1:0] hit_count
);

  localparam logic [MAX_WIDTH-1:0] ONES_FULL = all_ones(WIDTH);
  localparam logic [WIDTH-1:0]     ONES      = ONES_FULL[WIDTH-1:0];
  localparam logic [COUNT_W-1:0]   CNT_MAX   = '1;

  logic [WIDTH-1:0] w_and;
  logic             w_vld_in;
  logic [WIDTH-1:0] w_d [PIPE_STAGES+1];
  logic             w_v [PIPE_STAGES+1];
  logic [COUNT_W-1:0] r_cnt;

  assign w_and = a & b;

  // An X/Z in_valid falls through to the else path, so it counts as 0.
  always_comb begin
    w_vld_in = 1'b0;
    if (in_valid) w_vld_in = 1'b1;
  end

  assign w_d[0] = w_and;
  assign w_v[0] = w_vld_in;

  for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
    c_and_pipe_reg #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .i_d   (w_d[gi]),
      .i_vld (w_v[gi]),
      .o_d   (w_d[gi+1]),
      .o_vld (w_v[gi+1])
    );
  end

  if (PIPE_STAGES == 0) begin : g_bypass
    // y stays purely combinational; only the valid is masked by reset.
    assign y         = w_d[0];
    assign out_valid = w_v[0] & ~rst;
  end else begin : g_piped
    assign y         = w_d[PIPE_STAGES];
    assign out_valid = w_v[PIPE_STAGES];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (out_valid && (y == ONES) && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign hit_count = r_cnt;

endmodule

// File: tb/tb_c_and.sv
module tb_c_and;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b0;

  // WIDTH=1, N=0
  logic a0, b0, v0, y0, ov0;
  logic [15:0] hc0;
  // WIDTH=8, N=0
  logic [7:0] a8, b8, y8;
  logic v8, ov8;
  logic [15:0] hc8;
  // WIDTH=4, N=3
  logic [3:0] a4, b4, y4;
  logic v4, ov4;
  logic [15:0] hc4;
  // WIDTH=1, N=0, COUNT_W=2
  logic ac, bc, vc, yc, ovc;
  logic [1:0] hcc;

  int n_chk = 0;
  int n_fail = 0;

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  c_and #(.WIDTH(1), .PIPE_STAGES(0), .COUNT_W(16)) u0 (
    .clk(clk), .rst(rst), .a(a0), .b(b0), .in_valid(v0),
    .y(y0), .out_valid(ov0), .hit_count(hc0));

  c_and #(.WIDTH(8), .PIPE_STAGES(0), .COUNT_W(16)) u8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(v8),
    .y(y8), .out_valid(ov8), .hit_count(hc8));

  c_and #(.WIDTH(4), .PIPE_STAGES(3), .COUNT_W(16)) u4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(v4),
    .y(y4), .out_valid(ov4), .hit_count(hc4));

  c_and #(.WIDTH(1), .PIPE_STAGES(0), .COUNT_W(2)) uc (
    .clk(clk), .rst(rst), .a(ac), .b(bc), .in_valid(vc),
    .y(yc), .out_valid(ovc), .hit_count(hcc));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] ta, tb, ty;
    logic [1:0] cexp [5];
    ta = 5'b01010;  // index 0..4: 0,1,0,1,0
    tb = 5'b00110;  // index 0..4: 0,1,1,0,0
    ty = 5'b00010;  // index 0..4: 0,1,0,0,0
    cexp[0] = 2'd1; cexp[1] = 2'd2; cexp[2] = 2'd3; cexp[3] = 2'd3; cexp[4] = 2'd3;

    a0 = 0; b0 = 0; v0 = 1;
    a8 = 0; b8 = 0; v8 = 0;
    a4 = 0; b4 = 0; v4 = 0;
    ac = 0; bc = 0; vc = 0;

    // Truth table with the clock stopped
    for (int i = 0; i < 5; i++) begin
      a0 = ta[i]; b0 = tb[i];
      #100;
      chk($sformatf("tt_y[%0d]", i), {31'd0, y0}, {31'd0, ty[i]});
    end
    chk("tt_out_valid_comb", {31'd0, ov0}, 32'd1);

    // Bitwise, 8-bit
    a8 = 8'hF0; b8 = 8'h3C; v8 = 1;
    #10;
    chk("bw_F0_3C", {24'd0, y8}, 32'h30);
    chk("bw_out_valid", {31'd0, ov8}, 32'd1);
    v8 = 0;
    a8 = 8'hFF; b8 = 8'hFF;
    #10;
    chk("bw_FF_FF", {24'd0, y8}, 32'hFF);

    // Reset: N=0 y tracks a&b, out_valid forced low
    rst = 1; ac = 1; bc = 1; vc = 1;
    #1;
    chk("rst_n0_y_tracks", {31'd0, yc}, 32'd1);
    chk("rst_n0_out_valid", {31'd0, ovc}, 32'd0);
    clk_en = 1;
    tick; tick;
    chk("rst_n3_y", {28'd0, y4}, 32'd0);
    chk("rst_n3_out_valid", {31'd0, ov4}, 32'd0);
    chk("rst_hc4", {16'd0, hc4}, 32'd0);
    chk("rst_hcc_no_count", {30'd0, hcc}, 32'd0);
    chk("rst_hc0", {16'd0, hc0}, 32'd0);
    chk("rst_hc8", {16'd0, hc8}, 32'd0);
    ac = 0; bc = 0; vc = 0;
    rst = 0;

    // Latency N=3
    tick;
    a4 = 4'hF; b4 = 4'hF; v4 = 1;
    tick;
    a4 = 0; b4 = 0; v4 = 0;
    chk("lat_c1_y", {28'd0, y4}, 32'd0);
    chk("lat_c1_ov", {31'd0, ov4}, 32'd0);
    tick;
    chk("lat_c2_y", {28'd0, y4}, 32'd0);
    chk("lat_c2_ov", {31'd0, ov4}, 32'd0);
    tick;
    chk("lat_c3_y", {28'd0, y4}, 32'hF);
    chk("lat_c3_ov", {31'd0, ov4}, 32'd1);
    chk("lat_c3_hc", {16'd0, hc4}, 32'd0);
    tick;
    chk("lat_c4_y", {28'd0, y4}, 32'd0);
    chk("lat_c4_ov", {31'd0, ov4}, 32'd0);
    chk("lat_c4_hc", {16'd0, hc4}, 32'd1);

    // Reset with two results in flight
    a4 = 4'hF; b4 = 4'hF; v4 = 1;
    tick;
    tick;
    rst = 1; a4 = 0; b4 = 0; v4 = 0;
    tick;
    rst = 0;
    chk("mid_rst_y", {28'd0, y4}, 32'd0);
    chk("mid_rst_ov", {31'd0, ov4}, 32'd0);
    chk("mid_rst_hc", {16'd0, hc4}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick;
      chk($sformatf("mid_c%0d_y", i), {28'd0, y4}, 32'd0);
      chk($sformatf("mid_c%0d_ov", i), {31'd0, ov4}, 32'd0);
      chk($sformatf("mid_c%0d_hc", i), {16'd0, hc4}, 32'd0);
    end

    // Saturating counter, COUNT_W=2
    ac = 1; bc = 0; vc = 1;
    tick;
    chk("cnt_qual_zero", {30'd0, hcc}, 32'd0);
    ac = 1; bc = 1; vc = 0;
    tick;
    chk("cnt_unqual_ones", {30'd0, hcc}, 32'd0);
    vc = 1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk($sformatf("cnt_hit[%0d]", i), {30'd0, hcc}, {30'd0, cexp[i]});
    end
    vc = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
